// File: rtl/parser_pkg.sv
// Shared types and limits for the parser front-end.
package parser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_META
  } arb_state_t;

  localparam int MAX_PARSER_PORTS = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [N-1:0]  rot;
  logic [PW-1:0] src;
  int            off;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    rot = '0;
    src = '0;
    off = 0;
    for (int i = 0; i < N; i++) begin
      src    = PW'((i + int'(ptr)) % N);
      rot[i] = req[src];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    gnt_idx = PW'((off + int'(ptr)) % N);
    gnt_any = |req;
  end

endmodule

// File: rtl/parser_port_arbiter.sv
// Shares one packet parser between several AXI-Stream ports, one whole packet
// at a time, and tags each metadata result with the port it came from.
module parser_port_arbiter
  import parser_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int DATA_W       = 64,
  parameter int META_TIMEOUT = 255
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [NUM_PORTS*DATA_W-1:0]   s_axis_tdata,
  input  logic [NUM_PORTS-1:0]          s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]          s_axis_tlast,
  output logic [NUM_PORTS-1:0]          s_axis_tready,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  input  logic                          parser_meta_valid,
  output logic                          out_meta_valid,
  output logic [$clog2(NUM_PORTS)-1:0]  out_meta_port,
  output logic                          timeout_err,
  output logic                          busy
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int TW = $clog2(META_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(META_TIMEOUT - 1);

  arb_state_t    state;
  logic [PW-1:0] grant;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] next_ptr;
  logic [PW-1:0] win_idx;
  logic          win_any;
  logic          meta_seen;
  logic          meta_tag;
  logic          beat;
  logic [TW-1:0] timer;

  rr_arbiter #(.N(NUM_PORTS), .PW(PW)) u_rr (
    .req     (s_axis_tvalid),
    .ptr     (rr_ptr),
    .gnt_idx (win_idx),
    .gnt_any (win_any)
  );

  // Only the granted port is connected through, and only while streaming.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state == STREAM) begin
      m_axis_tdata         = s_axis_tdata[grant*DATA_W +: DATA_W];
      m_axis_tvalid        = s_axis_tvalid[grant];
      m_axis_tlast         = s_axis_tlast[grant];
      s_axis_tready[grant] = m_axis_tready;
    end
  end

  assign beat     = m_axis_tvalid & m_axis_tready;
  assign meta_tag = parser_meta_valid & ~meta_seen & (state != IDLE);
  assign next_ptr = (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
  assign busy     = (state != IDLE);

  // Pointer moves only when a packet completes, so no requester starves.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state          <= IDLE;
      grant          <= '0;
      rr_ptr         <= '0;
      meta_seen      <= 1'b0;
      timer          <= '0;
      out_meta_valid <= 1'b0;
      out_meta_port  <= '0;
      timeout_err    <= 1'b0;
    end else begin
      out_meta_valid <= meta_tag;
      timeout_err    <= 1'b0;
      if (meta_tag) begin
        out_meta_port <= grant;
        meta_seen     <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (win_any) begin
            grant     <= win_idx;
            meta_seen <= 1'b0;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (beat && m_axis_tlast) begin
            rr_ptr <= next_ptr;
            timer  <= '0;
            state  <= (meta_seen || parser_meta_valid) ? IDLE : WAIT_META;
          end
        end
        WAIT_META: begin
          // A late metadata pulse takes priority over the timeout.
          if (parser_meta_valid) begin
            state <= IDLE;
          end else if (timer == TIMER_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parser_port_arbiter.sv
// Directed bench for parser_port_arbiter: 4 ports, 64-bit data, 8-cycle meta timeout.
module tb_parser_port_arbiter;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int MT = 8;

  logic              aclk = 1'b0;
  logic              areset;
  logic [NP*DW-1:0]  s_axis_tdata;
  logic [NP-1:0]     s_axis_tvalid;
  logic [NP-1:0]     s_axis_tlast;
  logic [NP-1:0]     s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic              parser_meta_valid;
  logic              out_meta_valid;
  logic [1:0]        out_meta_port;
  logic              timeout_err;
  logic              busy;

  int compared   = 0;
  int mismatched = 0;

  parser_port_arbiter #(
    .NUM_PORTS    (NP),
    .DATA_W       (DW),
    .META_TIMEOUT (MT)
  ) dut (
    .aclk              (aclk),
    .areset            (areset),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tready     (s_axis_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tready     (m_axis_tready),
    .parser_meta_valid (parser_meta_valid),
    .out_meta_valid    (out_meta_valid),
    .out_meta_port     (out_meta_port),
    .timeout_err       (timeout_err),
    .busy              (busy)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beat word encodes port in [15:8] and beat number in [7:0].
  function automatic logic [63:0] beatWord(input int p, input int b);
    return 64'hBEEF_0000_0000_0000 | (64'(p) << 8) | 64'(b);
  endfunction

  task automatic setBeat(input int p, input int b, input logic last);
    s_axis_tdata[p*DW +: DW] = beatWord(p, b);
    s_axis_tlast[p]          = last;
  endtask

  task automatic applyStimulus(input logic [NP-1:0] valid, input logic mready, input logic meta);
    s_axis_tvalid     = valid;
    m_axis_tready     = mready;
    parser_meta_valid = meta;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic sample();
    @(negedge aclk);
  endtask

  task automatic doReset();
    areset = 1'b1;
    s_axis_tdata = '0;
    s_axis_tlast = '0;
    applyStimulus('0, 1'b0, 1'b0);
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bi[NP];
    int order[5];
    int pkt, cyc, first_k, pulses, omv_count, got, lasts, to_count;
    logic [NP-1:0] acc;
    logic mr, accd;

    // Reset with requests and parser ready active: nothing may leak through.
    areset = 1'b1;
    s_axis_tdata = '0;
    s_axis_tlast = '0;
    applyStimulus(4'b1111, 1'b1, 1'b1);
    repeat (2) @(negedge aclk);
    checkOutput("rst_busy", 64'(busy), 0);
    checkOutput("rst_mvalid", 64'(m_axis_tvalid), 0);
    checkOutput("rst_trdy", 64'(s_axis_tready), 0);
    checkOutput("rst_omv", 64'(out_meta_valid), 0);
    checkOutput("rst_omp", 64'(out_meta_port), 0);
    checkOutput("rst_to", 64'(timeout_err), 0);
    applyStimulus('0, 1'b0, 1'b0);
    areset = 1'b0;
    tick();

    // Single 3-beat packet from port 0 with metadata on beat 1.
    setBeat(0, 0, 1'b0);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    sample();
    checkOutput("t1_lat", 64'(m_axis_tvalid), 0);
    tick();
    sample();
    checkOutput("t1_valid", 64'(m_axis_tvalid), 1);
    checkOutput("t1_d0", m_axis_tdata, beatWord(0, 0));
    checkOutput("t1_trdy", 64'(s_axis_tready), 64'b0001);
    checkOutput("t1_busy", 64'(busy), 1);
    tick();
    setBeat(0, 1, 1'b0);
    applyStimulus(4'b0001, 1'b1, 1'b1);
    sample();
    checkOutput("t1_d1", m_axis_tdata, beatWord(0, 1));
    tick();
    setBeat(0, 2, 1'b1);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    sample();
    checkOutput("t1_omv", 64'(out_meta_valid), 1);
    checkOutput("t1_omp", 64'(out_meta_port), 0);
    checkOutput("t1_last", 64'(m_axis_tlast), 1);
    tick();
    applyStimulus('0, 1'b1, 1'b0);
    s_axis_tlast = '0;
    sample();
    checkOutput("t1_idle", 64'(busy), 0);
    checkOutput("t1_omv_off", 64'(out_meta_valid), 0);
    checkOutput("t1_mvalid_off", 64'(m_axis_tvalid), 0);
    tick();

    // All ports request continuously with 2-beat packets: order 0,1,2,3,0.
    doReset();
    order = '{0, 1, 2, 3, 0};
    foreach (bi[p]) bi[p] = 0;
    pkt = 0;
    cyc = 0;
    omv_count = 0;
    while (pkt < 5 && cyc < 60) begin
      for (int p = 0; p < NP; p++) setBeat(p, bi[p], bi[p] == 1);
      applyStimulus(4'b1111, 1'b1, 1'b1);
      sample();
      acc = s_axis_tready & s_axis_tvalid;
      if (out_meta_valid) begin
        omv_count++;
        checkOutput("t2_omp", 64'(out_meta_port), 64'(order[pkt]));
      end
      if (m_axis_tvalid) begin
        checkOutput("t2_port", 64'(m_axis_tdata[15:8]), 64'(order[pkt]));
        checkOutput("t2_beat", 64'(m_axis_tdata[7:0]), 64'(bi[order[pkt]]));
        checkOutput("t2_trdy", 64'(s_axis_tready), 64'(1) << order[pkt]);
        if (m_axis_tlast) pkt++;
      end
      tick();
      cyc++;
      for (int p = 0; p < NP; p++) if (acc[p]) bi[p] = (bi[p] + 1) % 2;
    end
    checkOutput("t2_pkts", 64'(pkt), 5);
    checkOutput("t2_tags", 64'(omv_count), 5);
    applyStimulus('0, 1'b1, 1'b0);
    s_axis_tlast = '0;
    tick();

    // Port 2 never gets metadata: timeout after 8 cycles, then port 3.
    setBeat(2, 0, 1'b0);
    setBeat(3, 0, 1'b0);
    applyStimulus(4'b1100, 1'b1, 1'b0);
    sample();
    checkOutput("t3_idle", 64'(busy), 0);
    tick();
    sample();
    checkOutput("t3_port", 64'(m_axis_tdata[15:8]), 2);
    checkOutput("t3_trdy", 64'(s_axis_tready), 64'b0100);
    tick();
    setBeat(2, 1, 1'b1);
    sample();
    checkOutput("t3_last", 64'(m_axis_tlast), 1);
    tick();
    applyStimulus(4'b1000, 1'b1, 1'b0);
    sample();
    checkOutput("t3_wait_trdy", 64'(s_axis_tready), 0);
    checkOutput("t3_wait_busy", 64'(busy), 1);
    checkOutput("t3_wait_mv", 64'(m_axis_tvalid), 0);
    first_k = -1;
    pulses = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      sample();
      if (timeout_err) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
      if (k == 9) begin
        checkOutput("t3_next_mv", 64'(m_axis_tvalid), 1);
        checkOutput("t3_next_port", 64'(m_axis_tdata[15:8]), 3);
      end
    end
    checkOutput("t3_to_cycle", 64'(first_k), 64'(MT));
    checkOutput("t3_pulses", 64'(pulses), 1);

    // Port 3 metadata arrives 3 cycles after tlast, pulsed twice.
    tick();
    setBeat(3, 1, 1'b1);
    sample();
    checkOutput("t4_last", 64'(m_axis_tlast), 1);
    tick();
    applyStimulus('0, 1'b1, 1'b0);
    s_axis_tlast = '0;
    sample();
    checkOutput("t4_wait1", 64'(busy), 1);
    tick();
    sample();
    checkOutput("t4_wait2", 64'(busy), 1);
    tick();
    applyStimulus('0, 1'b1, 1'b1);
    sample();
    checkOutput("t4_wait3", 64'(busy), 1);
    checkOutput("t4_no_omv", 64'(out_meta_valid), 0);
    tick();
    sample();
    checkOutput("t4_omv", 64'(out_meta_valid), 1);
    checkOutput("t4_omp", 64'(out_meta_port), 3);
    checkOutput("t4_busy", 64'(busy), 0);
    checkOutput("t4_to", 64'(timeout_err), 0);
    tick();
    applyStimulus('0, 1'b1, 1'b0);
    sample();
    checkOutput("t4_omv2", 64'(out_meta_valid), 0);
    checkOutput("t4_omp_hold", 64'(out_meta_port), 3);
    tick();

    // Metadata lands on the very cycle the timer expires: meta wins.
    setBeat(0, 0, 1'b1);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    tick();
    tick();
    applyStimulus('0, 1'b1, 1'b0);
    s_axis_tlast = '0;
    to_count = 0;
    repeat (MT - 1) begin
      tick();
      sample();
      if (timeout_err) to_count++;
    end
    applyStimulus('0, 1'b1, 1'b1);
    tick();
    applyStimulus('0, 1'b1, 1'b0);
    sample();
    checkOutput("tb_to", 64'(timeout_err), 0);
    checkOutput("tb_omv", 64'(out_meta_valid), 1);
    checkOutput("tb_omp", 64'(out_meta_port), 0);
    checkOutput("tb_busy", 64'(busy), 0);
    tick();
    sample();
    if (timeout_err) to_count++;
    checkOutput("tb_to_count", 64'(to_count), 0);
    tick();

    // Port 1, 4 beats, parser ready toggling every cycle.
    got = 0;
    lasts = 0;
    cyc = 0;
    bi[1] = 0;
    while (bi[1] < 4 && cyc < 30) begin
      mr = (cyc % 2 == 0);
      setBeat(1, bi[1], bi[1] == 3);
      applyStimulus(4'b0010, mr, 1'b1);
      sample();
      if (m_axis_tvalid) checkOutput("t5_trdy", 64'(s_axis_tready), 64'({2'b00, mr, 1'b0}));
      if (m_axis_tvalid && mr) begin
        checkOutput("t5_beat", 64'(m_axis_tdata[7:0]), 64'(got));
        got++;
        if (m_axis_tlast) lasts++;
      end
      accd = s_axis_tready[1] && s_axis_tvalid[1];
      tick();
      cyc++;
      if (accd) bi[1]++;
    end
    checkOutput("t5_beats", 64'(got), 4);
    checkOutput("t5_lasts", 64'(lasts), 1);
    applyStimulus('0, 1'b1, 1'b0);
    s_axis_tlast = '0;
    tick();

    // Asynchronous reset in the middle of a port 3 packet.
    setBeat(3, 0, 1'b0);
    applyStimulus(4'b1000, 1'b1, 1'b0);
    tick();
    sample();
    checkOutput("t6_grant3", 64'(m_axis_tdata[15:8]), 3);
    setBeat(0, 0, 1'b0);
    applyStimulus(4'b1001, 1'b1, 1'b0);
    #2;
    areset = 1'b1;
    #1;
    checkOutput("t6_busy", 64'(busy), 0);
    checkOutput("t6_mv", 64'(m_axis_tvalid), 0);
    checkOutput("t6_trdy", 64'(s_axis_tready), 0);
    checkOutput("t6_omv", 64'(out_meta_valid), 0);
    checkOutput("t6_to", 64'(timeout_err), 0);
    @(negedge aclk);
    areset = 1'b0;
    tick();
    sample();
    checkOutput("t6_port0", 64'(m_axis_tdata[15:8]), 0);
    checkOutput("t6_trdy0", 64'(s_axis_tready), 64'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/parser_port_arbiter.md
Name: parser_port_arbiter

Overview:
Shares one packet_parser_top instance between NUM_PORTS AXI-Stream ingress ports at packet granularity.
- Grants one port in round-robin order and forwards its whole packet (through tlast) to the parser.
- Holds the grant until the parser's meta_valid for that packet has been seen, or a timeout expires.
- Tags each metadata result with the source port id.

Parameters:
NUM_PORTS, 4, number of ingress requesters (2..16)
DATA_W, 64, AXIS data width in bits
META_TIMEOUT, 255, max cycles to wait for meta_valid after tlast (1..65535)

Ports:
aclk  input  1  clock
areset  input  1  asynchronous active-high reset
s_axis_tdata  input  NUM_PORTS*DATA_W  ingress data; port i occupies bits [i*DATA_W +: DATA_W]
s_axis_tvalid  input  NUM_PORTS  ingress valid per port
s_axis_tlast  input  NUM_PORTS  ingress last per port
s_axis_tready  output  NUM_PORTS  ingress ready per port
m_axis_tdata  output  DATA_W  data to parser
m_axis_tvalid  output  1  valid to parser
m_axis_tlast  output  1  last to parser
m_axis_tready  input  1  parser ready
parser_meta_valid  input  1  parser metadata-valid pulse
out_meta_valid  output  1  registered pulse: metadata belongs to out_meta_port
out_meta_port  output  $clog2(NUM_PORTS)  source port of current metadata
timeout_err  output  1  one-cycle pulse: meta wait timed out
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock aclk; reset areset, asynchronous, active-high. Async assertion of areset forces all registers to reset immediately.
- Reset values: state=IDLE, grant=0, rr_ptr=0, meta_seen=0, timer=0. All outputs 0: s_axis_tready, m_axis_*, out_meta_valid, out_meta_port, timeout_err, busy.
- States: IDLE, STREAM, WAIT_META.
- IDLE:
  - Request vector = s_axis_tvalid.
  - If any bit is set, rr_arbiter selects the first set bit at or after rr_ptr, wrapping modulo NUM_PORTS.
  - Next cycle: grant <= winner, state <= STREAM, meta_seen <= 0.
  - Grant latency is 1 cycle from first tvalid to m_axis_tvalid.
  - parser_meta_valid in IDLE is ignored.
- STREAM:
  - m_axis_tdata/tvalid/tlast = s_axis_*[grant] (combinational).
  - s_axis_tready[grant] = m_axis_tready; all other tready bits are 0.
  - A beat transfers when tvalid & tready.
  - parser_meta_valid here sets meta_seen; the parser completes headers before tlast.
  - On accepted tlast beat:
    - if meta_seen, or parser_meta_valid in the same cycle, go to IDLE;
    - otherwise go to WAIT_META with timer <= 0.
  - Either way rr_ptr <= grant+1 (wrap at NUM_PORTS).
- WAIT_META:
  - All s_axis_tready = 0; m_axis_tvalid = 0.
  - Timer increments each cycle.
  - parser_meta_valid moves to IDLE.
  - timer == META_TIMEOUT-1 without meta: timeout_err pulses 1 cycle, go to IDLE.
  - If meta arrives on the timeout cycle, meta wins: no timeout_err.
- Metadata tagging:
  - The first parser_meta_valid per packet, in STREAM or WAIT_META, produces out_meta_valid=1 on the next cycle, with out_meta_port = grant.
  - out_meta_port holds its value until the next tag.
  - Further pulses for the same packet are ignored.
- Ungranted ports keep tvalid pending and are never dropped.
- rr_ptr advances only on packet completion, so each requesting port waits at most NUM_PORTS-1 packets.
- No packet interleaving: a grant never changes mid-packet.
- Timer width is $clog2(META_TIMEOUT+1) and saturates; no wrap.

Decomposition:
- parser_pkg gains:
  - arb_state_t enum {IDLE, STREAM, WAIT_META};
  - localparam MAX_PARSER_PORTS=16.
- Sub-module rr_arbiter (parameter N) is combinational:
  - inputs req[N], ptr;
  - outputs gnt_idx, gnt_any;
  - implemented as rotate, priority-encode, un-rotate.
- The top-level FSM, timer and tagging logic sit in parser_port_arbiter.

Test Plan:
- Single port 0, 3-beat packet, tready=1, meta at beat 1:
  - m_axis_tvalid rises 1 cycle after s_axis_tvalid[0];
  - out_meta_valid the cycle after meta with out_meta_port=0;
  - returns IDLE right after tlast;
  - busy=0.
- All 4 ports request continuously with 2-beat packets: grant order 0,1,2,3,0; no beat from a non-granted port appears on m_axis.
- Port 2 packet with meta never asserted, META_TIMEOUT=8: timeout_err pulses exactly 8 cycles after tlast; port 3 is granted next.
- Meta arrives 3 cycles after tlast: state stays WAIT_META, then out_meta_valid=1 with port id preserved; two meta pulses yield only one out_meta_valid.
- m_axis_tready toggled 1/0 every cycle on a 4-beat packet from port 1: beats stay in order, tlast is accepted once, and s_axis_tready[1] mirrors m_axis_tready.
- areset asserted mid-STREAM on port 3: all outputs 0 immediately; after release, port 0 wins if requesting (rr_ptr=0).
